lab2_proc_mem_responder: RTL and testbench

LAB2_PROC_MEM_RESPONDER -- requirements
Module: lab2_proc_mem_responder

---
 rtl/lab2_proc_mem_responder.sv | 159 +++++++++++++++
 tb/tb_lab2_proc_mem_responder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab2_proc_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lab2_proc_mem_responder: single-outstanding val/rdy word memory with    |
// | byte-lane stores, shifted loads and a fixed, configurable response wait. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lab2_proc_mem_responder #(
  parameter int p_num_words = 256,
  parameter int p_latency   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreq_val,
  output logic        memreq_rdy,
  input  logic [2:0]  memreq_msg_type,
  input  logic [7:0]  memreq_msg_opaque,
  input  logic [31:0] memreq_msg_addr,
  input  logic [1:0]  memreq_msg_len,
  input  logic [31:0] memreq_msg_data,
  output logic        memresp_val,
  input  logic        memresp_rdy,
  output logic [2:0]  memresp_msg_type,
  output logic [7:0]  memresp_msg_opaque,
  output logic [1:0]  memresp_msg_test,
  output logic [1:0]  memresp_msg_len,
  output logic [31:0] memresp_msg_data
);

  localparam int         c_IDX_W      = $clog2(p_num_words);
  localparam logic [3:0] c_LATENCY    = 4'(p_latency);
  localparam logic [2:0] c_TYPE_READ  = 3'd0;
  localparam logic [2:0] c_TYPE_WRITE = 3'd1;
  localparam logic [2:0] c_TYPE_INIT  = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  type_q, type_d;
  logic [7:0]  opaque_q, opaque_d;
  logic [1:0]  len_q, len_d;
  logic [31:0] data_q, data_d;

  logic [31:0] mem_q [p_num_words];

  logic               w_req_fire;
  logic               w_is_store;
  logic [c_IDX_W-1:0] w_idx;
  logic [1:0]         w_off;
  logic [2:0]         w_cnt;
  logic [31:0]        w_word;
  logic [3:0]         w_wr_lane;
  logic [3:0]         w_rd_lane;
  logic [31:0]        w_wr_mask;
  logic [31:0]        w_rd_mask;
  logic [31:0]        w_wr_shift;
  logic [31:0]        w_wr_word;
  logic [31:0]        w_rd_data;
  logic               w_unused_addr;

  assign memreq_rdy = (state_q == ST_IDLE) || ((state_q == ST_RESP) && memresp_rdy);
  assign w_req_fire = memreq_val && memreq_rdy;

  // Upper address bits are ignored so accesses wrap modulo the memory depth.
  assign w_idx         = memreq_msg_addr[c_IDX_W+1:2];
  assign w_unused_addr = ^memreq_msg_addr[31:c_IDX_W+2];
  assign w_off         = memreq_msg_addr[1:0];
  assign w_cnt         = (memreq_msg_len == 2'd0) ? 3'd4 : {1'b0, memreq_msg_len};
  assign w_is_store    = (memreq_msg_type == c_TYPE_WRITE) || (memreq_msg_type == c_TYPE_INIT);
  assign w_word        = mem_q[w_idx];

  // Store lanes past byte 3 fall off the word instead of wrapping.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign w_wr_lane[i] = (3'(i) >= {1'b0, w_off}) && (3'(i) < ({1'b0, w_off} + w_cnt));
    assign w_rd_lane[i] = 3'(i) < w_cnt;
    assign w_wr_mask[8*i +: 8] = {8{w_wr_lane[i]}};
    assign w_rd_mask[8*i +: 8] = {8{w_rd_lane[i]}};
  end

  assign w_wr_shift = memreq_msg_data << {w_off, 3'b000};
  assign w_wr_word  = (w_word & ~w_wr_mask) | (w_wr_shift & w_wr_mask);
  assign w_rd_data  = (w_word >> {w_off, 3'b000}) & w_rd_mask;

  always_ff @(posedge clk) begin
    if (w_req_fire && w_is_store && !reset) begin
      mem_q[w_idx] <= w_wr_word;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    type_d   = type_q;
    opaque_d = opaque_q;
    len_d    = len_q;
    data_d   = data_q;
    if (w_req_fire) begin
      type_d   = memreq_msg_type;
      opaque_d = memreq_msg_opaque;
      len_d    = memreq_msg_len;
      data_d   = (memreq_msg_type == c_TYPE_READ) ? w_rd_data : 32'd0;
      if (c_LATENCY == 4'd0) begin
        state_d = ST_RESP;
        cnt_d   = 4'd0;
      end else begin
        state_d = ST_WAIT;
        cnt_d   = c_LATENCY;
      end
    end else begin
      case (state_q)
        ST_WAIT: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d = ST_RESP;
          end
        end
        ST_RESP: begin
          if (memresp_rdy) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      type_q   <= 3'd0;
      opaque_q <= 8'd0;
      len_q    <= 2'd0;
      data_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      type_q   <= type_d;
      opaque_q <= opaque_d;
      len_q    <= len_d;
      data_q   <= data_d;
    end
  end

  assign memresp_val        = (state_q == ST_RESP);
  assign memresp_msg_type   = type_q;
  assign memresp_msg_opaque = opaque_q;
  assign memresp_msg_test   = 2'b00;
  assign memresp_msg_len    = len_q;
  assign memresp_msg_data   = data_q;

endmodule
`default_nettype wire

// File: tb/tb_lab2_proc_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lab2_proc_mem_responder: two responders (zero and three wait cycles)  |
// | checked each cycle against a byte-level transaction model.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_lab2_proc_mem_responder;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        req_val   [2];
  logic        req_rdy   [2];
  logic [2:0]  req_type  [2];
  logic [7:0]  req_op    [2];
  logic [31:0] req_addr  [2];
  logic [1:0]  req_len   [2];
  logic [31:0] req_data  [2];
  logic        resp_val  [2];
  logic        resp_rdy  [2];
  logic [2:0]  resp_type [2];
  logic [7:0]  resp_op   [2];
  logic [1:0]  resp_test [2];
  logic [1:0]  resp_len  [2];
  logic [31:0] resp_data [2];

  int nvec = 0;
  int nmis = 0;
  int ncyc = 0;

  always #5 clk = ~clk;

  lab2_proc_mem_responder #(.p_num_words(256), .p_latency(0)) dut0 (
    .clk(clk), .reset(rst[0]),
    .memreq_val(req_val[0]), .memreq_rdy(req_rdy[0]),
    .memreq_msg_type(req_type[0]), .memreq_msg_opaque(req_op[0]),
    .memreq_msg_addr(req_addr[0]), .memreq_msg_len(req_len[0]),
    .memreq_msg_data(req_data[0]),
    .memresp_val(resp_val[0]), .memresp_rdy(resp_rdy[0]),
    .memresp_msg_type(resp_type[0]), .memresp_msg_opaque(resp_op[0]),
    .memresp_msg_test(resp_test[0]), .memresp_msg_len(resp_len[0]),
    .memresp_msg_data(resp_data[0])
  );

  lab2_proc_mem_responder #(.p_num_words(256), .p_latency(3)) dut1 (
    .clk(clk), .reset(rst[1]),
    .memreq_val(req_val[1]), .memreq_rdy(req_rdy[1]),
    .memreq_msg_type(req_type[1]), .memreq_msg_opaque(req_op[1]),
    .memreq_msg_addr(req_addr[1]), .memreq_msg_len(req_len[1]),
    .memreq_msg_data(req_data[1]),
    .memresp_val(resp_val[1]), .memresp_rdy(resp_rdy[1]),
    .memresp_msg_type(resp_type[1]), .memresp_msg_opaque(resp_op[1]),
    .memresp_msg_test(resp_test[1]), .memresp_msg_len(resp_len[1]),
    .memresp_msg_data(resp_data[1])
  );

  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s inst%0d cycle %0d: got %h expected %h", nm, i, ncyc, act, exp);
    end
  endtask

  // Transaction model: one outstanding request per instance, memory as bytes.
  logic [7:0]  mb [2][1024];
  bit          busy [2];
  int          due [2];
  logic [2:0]  e_type [2];
  logic [7:0]  e_op [2];
  logic [1:0]  e_len [2];
  logic [31:0] e_data [2];
  int          acc_cyc [2];
  int          first_val [2];
  bit          seen [2];
  logic [2:0]  last_type [2];
  logic [7:0]  last_op [2];
  logic [31:0] last_data [2];

  always @(negedge clk) begin
    ncyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        busy[i] = 1'b0;
      end else begin
        bit ev;
        bit er;
        int w;
        int off;
        int cnt;
        ev = busy[i] && (ncyc >= due[i]);
        er = !busy[i] || (ev && resp_rdy[i]);
        chk("resp_val", i, 32'(resp_val[i]), 32'(ev));
        chk("req_rdy", i, 32'(req_rdy[i]), 32'(er));
        if (ev) begin
          chk("resp_type", i, 32'(resp_type[i]), 32'(e_type[i]));
          chk("resp_opaque", i, 32'(resp_op[i]), 32'(e_op[i]));
          chk("resp_test", i, 32'(resp_test[i]), 32'd0);
          chk("resp_len", i, 32'(resp_len[i]), 32'(e_len[i]));
          chk("resp_data", i, resp_data[i], e_data[i]);
          if (!seen[i]) begin
            first_val[i] = ncyc;
            seen[i] = 1'b1;
          end
          if (resp_rdy[i]) begin
            busy[i] = 1'b0;
            last_type[i] = resp_type[i];
            last_op[i] = resp_op[i];
            last_data[i] = resp_data[i];
          end
        end
        if (req_val[i] && er) begin
          w   = int'(req_addr[i][9:2]);
          off = int'(req_addr[i][1:0]);
          cnt = (req_len[i] == 2'd0) ? 4 : int'(req_len[i]);
          e_type[i] = req_type[i];
          e_op[i]   = req_op[i];
          e_len[i]  = req_len[i];
          e_data[i] = 32'd0;
          for (int k = 0; k < cnt; k++) begin
            if (off + k < 4) begin
              if (req_type[i] == 3'd1 || req_type[i] == 3'd2)
                mb[i][w*4 + off + k] = req_data[i][8*k +: 8];
              else if (req_type[i] == 3'd0)
                e_data[i][8*k +: 8] = mb[i][w*4 + off + k];
            end
          end
          busy[i] = 1'b1;
          due[i] = ncyc + 1 + ((i == 0) ? 0 : 3);
          acc_cyc[i] = ncyc;
          seen[i] = 1'b0;
        end
      end
    end
  end

  task automatic do_req(int i, logic [2:0] t, logic [7:0] op, logic [31:0] a,
                        logic [1:0] l, logic [31:0] d);
    bit got;
    got = 1'b0;
    req_type[i] = t; req_op[i] = op; req_addr[i] = a; req_len[i] = l; req_data[i] = d;
    req_val[i] = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (req_rdy[i]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("req_accept_timeout", i, 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle(int i);
    req_val[i] = 1'b0;
  endtask

  task automatic wait_resp(int i);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (resp_val[i] && resp_rdy[i]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("resp_timeout", i, 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic rd(int i, logic [7:0] op, logic [31:0] a, logic [1:0] l, logic [31:0] exp, string nm);
    do_req(i, 3'd0, op, a, l, 32'd0);
    idle(i);
    wait_resp(i);
    chk(nm, i, last_data[i], exp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a1;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; req_val[i] = 1'b0; resp_rdy[i] = 1'b1;
      req_type[i] = '0; req_op[i] = '0; req_addr[i] = '0; req_len[i] = '0; req_data[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    chk("post_reset_val", 0, 32'(resp_val[0]), 32'd0);
    chk("post_reset_rdy", 0, 32'(req_rdy[0]), 32'd1);
    chk("post_reset_data", 0, resp_data[0], 32'd0);
    chk("post_reset_type", 1, 32'(resp_type[1]), 32'd0);
    @(posedge clk); #1;

    // Write then read at zero wait cycles.
    do_req(0, 3'd1, 8'h05, 32'h1000, 2'd0, 32'hdeadbeef);
    idle(0);
    wait_resp(0);
    chk("wr_latency", 0, 32'(first_val[0] - acc_cyc[0]), 32'd1);
    chk("wr_type", 0, 32'(last_type[0]), 32'd1);
    chk("wr_opaque", 0, 32'(last_op[0]), 32'h05);
    chk("wr_data", 0, last_data[0], 32'd0);
    rd(0, 8'h06, 32'h1000, 2'd0, 32'hdeadbeef, "rd_after_wr");
    chk("rd_latency", 0, 32'(first_val[0] - acc_cyc[0]), 32'd1);

    // Sub-word access, issued back to back.
    do_req(0, 3'd2, 8'h10, 32'h0, 2'd0, 32'h11223344);
    do_req(0, 3'd1, 8'h11, 32'h2, 2'd1, 32'h000000aa);
    rd(0, 8'h12, 32'h0, 2'd0, 32'h11aa3344, "subword_full");
    rd(0, 8'h13, 32'h2, 2'd2, 32'h000011aa, "subword_half");

    // Address wrap, then a store that runs past byte 3.
    do_req(0, 3'd1, 8'h20, 32'h400, 2'd0, 32'h5);
    rd(0, 8'h21, 32'h0, 2'd0, 32'h5, "wrap");
    do_req(0, 3'd1, 8'h22, 32'h3, 2'd0, 32'hccddeeff);
    rd(0, 8'h23, 32'h0, 2'd0, 32'hff000005, "lane_drop");
    rd(0, 8'h24, 32'h3, 2'd0, 32'h000000ff, "rd_off3");

    // Unknown type leaves memory alone and returns zero data.
    do_req(0, 3'd5, 8'h25, 32'h0, 2'd0, 32'h12345678);
    idle(0);
    wait_resp(0);
    chk("type5_type", 0, 32'(last_type[0]), 32'd5);
    chk("type5_data", 0, last_data[0], 32'd0);
    rd(0, 8'h26, 32'h0, 2'd0, 32'hff000005, "type5_nowrite");

    // Backpressure with a queued request.
    resp_rdy[0] = 1'b0;
    do_req(0, 3'd0, 8'h30, 32'h0, 2'd0, 32'd0);
    req_type[0] = 3'd1; req_op[0] = 8'h31; req_addr[0] = 32'h8;
    req_len[0] = 2'd0; req_data[0] = 32'h01020304; req_val[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_val", 0, 32'(resp_val[0]), 32'd1);
      chk("bp_rdy", 0, 32'(req_rdy[0]), 32'd0);
      chk("bp_data", 0, resp_data[0], 32'hff000005);
      chk("bp_opaque", 0, 32'(resp_op[0]), 32'h30);
    end
    @(posedge clk); #1;
    resp_rdy[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_rdy", 0, 32'(req_rdy[0]), 32'd1);
    @(posedge clk); #1;
    idle(0);
    wait_resp(0);
    chk("bp_queued_opaque", 0, 32'(last_op[0]), 32'h31);
    rd(0, 8'h32, 32'h8, 2'd0, 32'h01020304, "bp_queued_write");

    // Three wait cycles: a held request is accepted only when the response fires.
    do_req(1, 3'd1, 8'h40, 32'h20, 2'd0, 32'hcafef00d);
    a1 = acc_cyc[1];
    do_req(1, 3'd0, 8'h41, 32'h20, 2'd0, 32'd0);
    chk("l3_first_val", 1, 32'(first_val[1] - a1), 32'd4);
    chk("l3_accept_gap", 1, 32'(acc_cyc[1] - a1), 32'd4);
    idle(1);
    wait_resp(1);
    chk("l3_rd_data", 1, last_data[1], 32'hcafef00d);
    chk("l3_rd_latency", 1, 32'(first_val[1] - acc_cyc[1]), 32'd4);

    // Reset while waiting discards the response but keeps memory.
    do_req(1, 3'd1, 8'h50, 32'h40, 2'd0, 32'h77);
    idle(1);
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    @(negedge clk);
    chk("rst_wait_rdy", 1, 32'(req_rdy[1]), 32'd1);
    chk("rst_wait_val", 1, 32'(resp_val[1]), 32'd0);
    chk("rst_wait_data", 1, resp_data[1], 32'd0);
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    rd(1, 8'h51, 32'h40, 2'd0, 32'h77, "rst_keep_new");
    rd(1, 8'h52, 32'h20, 2'd0, 32'hcafef00d, "rst_keep_old");

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
`default_nettype wire
